// File: rtl/cpu_pkg.sv
// Shared types and instruction field positions for the LEGv8 core.
package cpu_pkg;

  typedef enum logic {
    S_FETCH,
    S_HOLD
  } fetch_state_t;

  localparam int INST_W    = 32;
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 21;
  localparam int IMM26_MSB = 25;
  localparam int IMM26_LSB = 0;
  localparam int IMM19_MSB = 23;
  localparam int IMM19_LSB = 5;
  localparam int IMM26_W   = IMM26_MSB - IMM26_LSB + 1;
  localparam int IMM19_W   = IMM19_MSB - IMM19_LSB + 1;

endpackage

// File: rtl/next_pc_calc.sv
// Branch resolution and next-PC adders for the fetch stage.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0]  inst_pc,
  input  logic [IMM26_MSB:0] imm_field,
  input  logic               UnCondBr,
  input  logic               BrZero,
  input  logic               BrLessThan,
  input  logic               alu_z,
  input  logic               flag_n,
  input  logic               flag_v,
  output logic               br_taken,
  output logic [ADDR_W-1:0]  next_pc
);

  logic [IMM26_W-1:0] imm26;
  logic [IMM19_W-1:0] imm19;
  logic [ADDR_W-1:0]  imm_ext;
  logic [ADDR_W-1:0]  target;

  assign imm26 = imm_field[IMM26_MSB:IMM26_LSB];
  assign imm19 = imm_field[IMM19_MSB:IMM19_LSB];

  assign br_taken = UnCondBr
                  | (BrZero & alu_z)
                  | (BrLessThan & (flag_n != flag_v));

  // imm26 wins whenever UnCondBr is set, even alongside a conditional
  always_comb begin
    imm_ext = '0;
    if (UnCondBr)
      imm_ext = {{(ADDR_W-IMM26_W){imm26[IMM26_W-1]}}, imm26};
    else
      imm_ext = {{(ADDR_W-IMM19_W){imm19[IMM19_W-1]}}, imm19};
  end

  assign target  = inst_pc + (imm_ext << 2);
  assign next_pc = br_taken ? target : inst_pc + ADDR_W'(4);

endmodule

// File: rtl/fetch_unit.sv
// Fetch/PC stage with NZVC flag register.
// Optional FETCH_PERF_CNT_EN adds instret/stall_cyc counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              UnCondBr,
  input  logic              BrZero,
  input  logic              BrLessThan,
  input  logic              SetFlags,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_c,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       instret,
  output logic [31:0]       stall_cyc,
`endif
  output logic [3:0]        flags
);

  fetch_state_t      state, state_d;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              br_taken;
  logic              fetch_done;
  logic              retire;

  // Request is masked during reset so a late response is dropped
  assign imem_req   = (state == S_FETCH) & ~reset;
  assign imem_addr  = pc;
  assign inst_valid = (state == S_HOLD);
  assign fetch_done = imem_req & imem_valid;
  assign retire     = inst_valid & inst_ready;

  always_comb begin
    state_d = state;
    unique case (state)
      S_FETCH: if (fetch_done) state_d = S_HOLD;
      S_HOLD:  if (retire)     state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      inst    <= '0;
      inst_pc <= RESET_PC;
      flags   <= 4'b0000;
    end else begin
      state <= state_d;
      if (fetch_done) begin
        inst    <= imem_rdata;
        inst_pc <= pc;
      end
      if (retire) begin
        pc <= next_pc;
        if (SetFlags)
          flags <= {alu_n, alu_z, alu_v, alu_c};
      end
    end
  end

  next_pc_calc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .inst_pc   (inst_pc),
    .imm_field (inst[IMM26_MSB:0]),
    .UnCondBr  (UnCondBr),
    .BrZero    (BrZero),
    .BrLessThan(BrLessThan),
    .alu_z     (alu_z),
    .flag_n    (flags[3]),
    .flag_v    (flags[1]),
    .br_taken  (br_taken),
    .next_pc   (next_pc)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      instret   <= '0;
      stall_cyc <= '0;
    end else begin
      if (retire)
        instret <= instret + 32'd1;
      if (imem_req & ~imem_valid)
        stall_cyc <= stall_cyc + 32'd1;
    end
  end
`endif

endmodule
